// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: collects WIDTH bits LSB first, starting on
// sync, and queues finished words in a 2-entry FIFO with sticky error flags.
module serial_word_rx #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   input  logic             sync,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   input  logic             clr_err,
   output logic             overflow,
   output logic             frame_err
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

   typedef enum logic [0:0] {StHunt, StRecv} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    bitcnt_q;
   // Bits arrive LSB first and shift down from the top; bit 0 reaches
   // position 0 just as the final bit is presented on sin.
   logic [WIDTH-2:0] shreg_q;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] e0_q, e1_q;
   logic [1:0]       count_q;
   logic             start, shift, word_done, frame_evt;
   logic             push, pop, ovf_evt;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= StHunt;
      else       state_q <= state_d;
   end

   // FSM next state: leave RECV only after the last bit without a resync
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StHunt: if (sync) state_d = StRecv;
         StRecv: if (!sync && bitcnt_q == LastBit) state_d = StHunt;
         default: state_d = StHunt;
      endcase
   end

   // FSM outputs: datapath controls and framing error event
   always_comb begin
      start     = 1'b0;
      shift     = 1'b0;
      word_done = 1'b0;
      frame_evt = 1'b0;
      unique case (state_q)
         StHunt: start = sync;
         StRecv: begin
            if (sync) begin
               start     = 1'b1;
               frame_evt = 1'b1;
            end else begin
               shift     = 1'b1;
               word_done = (bitcnt_q == LastBit);
            end
         end
         default: ;
      endcase
   end

   assign word = {sin, shreg_q};

   // Bit counter and shift register; a sync restarts the word with this sin as bit 0
   always_ff @(posedge clk) begin
      if (reset) begin
         bitcnt_q <= '0;
         shreg_q  <= '0;
      end else if (start) begin
         bitcnt_q <= CW'(1);
         shreg_q  <= {sin, {(WIDTH-2){1'b0}}};
      end else if (shift) begin
         bitcnt_q <= bitcnt_q + CW'(1);
         shreg_q  <= {sin, shreg_q[WIDTH-2:1]};
      end
   end

   assign push       = word_done;
   assign dout_valid = (count_q != 2'd0);
   assign pop        = dout_valid && dout_ready;
   // A pop on the same edge frees the slot, so only a push with no pop into a full FIFO drops
   assign ovf_evt    = push && !pop && (count_q == 2'd2);
   assign dout       = e0_q;

   // Two-entry FIFO; e0 is always the head
   always_ff @(posedge clk) begin
      if (reset) begin
         e0_q    <= '0;
         e1_q    <= '0;
         count_q <= 2'd0;
      end else if (pop && push) begin
         if (count_q == 2'd2) begin
            e0_q <= e1_q;
            e1_q <= word;
         end else begin
            e0_q <= word;
         end
      end else if (pop) begin
         e0_q    <= e1_q;
         count_q <= count_q - 2'd1;
      end else if (push) begin
         if (count_q == 2'd0) begin
            e0_q    <= word;
            count_q <= 2'd1;
         end else if (count_q == 2'd1) begin
            e1_q    <= word;
            count_q <= 2'd2;
         end
      end
   end

   // Sticky error flags; a new event wins over clr_err on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (ovf_evt)      overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;
         if (frame_evt)    frame_err <= 1'b1;
         else if (clr_err) frame_err <= 1'b0;
      end
   end

endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning word width in bits; only 64 is required to be supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sin  input  1  serial data bit, LSB first.
REQ-005 SHALL have port sync  input  1  marks the cycle in which sin carries bit 0 of a word.
REQ-006 SHALL have port dout  output  64  head word of the output buffer.
REQ-007 SHALL have port dout_valid  output  1  dout holds a valid word.
REQ-008 SHALL have port dout_ready  input  1  consumer accepts dout when dout_valid is high.
REQ-009 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-010 SHALL have port overflow  output  1  sticky flag: a completed word was dropped.
REQ-011 SHALL have port frame_err  output  1  sticky flag: sync arrived mid-word.

Function
REQ-012 SHALL use a two-state FSM: HUNT (waiting for sync) and RECV (collecting bits 1..63).
REQ-013 In HUNT with sync=0, SHALL ignore sin and remain in HUNT.
REQ-014 In HUNT with sync=1, SHALL capture sin as bit 0, set the bit counter to 1, and go to RECV.
REQ-015 In RECV with sync=0, SHALL capture sin as bit number bitcnt and increment bitcnt (6-bit).
REQ-016 In RECV, when bit 63 is captured, SHALL form the word {sin, bits 62..0}, push it to the buffer on that same edge, and go to HUNT.
REQ-017 Back-to-back words (sync every 64 cycles) SHALL be received with no lost cycles.
REQ-018 In RECV with sync=1 (bitcnt 1..63), SHALL set frame_err, discard the partial word, treat this sin as bit 0 of a new word, set bitcnt to 1, and stay in RECV.
REQ-019 The buffer SHALL be a 2-entry FIFO; dout SHALL equal the oldest entry and dout_valid SHALL equal "FIFO not empty".
REQ-020 A pop SHALL occur on any edge where dout_valid=1 and dout_ready=1.
REQ-021 A push to a full FIFO SHALL drop the new word and set overflow, unless a pop occurs on the same edge, in which case the push SHALL be accepted and overflow SHALL not be set.
REQ-022 Latency: if sync is high in cycle 0, dout_valid SHALL be high in cycle 64 when the FIFO was empty.
REQ-023 dout SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-024 clr_err=1 SHALL clear overflow and frame_err on the next edge; a new error event on the same edge SHALL take priority (flag set).
REQ-025 dout_ready SHALL have no effect when dout_valid=0.

Reset
REQ-026 On reset: state HUNT, bitcnt=0, FIFO empty, dout_valid=0, dout=64'h0, overflow=0, frame_err=0.
REQ-027 Reset SHALL take priority over all inputs; a partial word in progress SHALL be discarded.
REQ-028 The first word after reset SHALL begin only with a sync in or after the first cycle with reset=0.

Verification
REQ-029 Single word: dout_ready=1; serialize 64'h0123_4567_89AB_CDEF LSB-first with sync in cycle 0 -> dout_valid high in cycle 64 with dout=64'h0123_4567_89AB_CDEF for exactly 1 cycle.
REQ-030 Streaming: 4 words 64'h1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA5A5_A5A5_5A5A_5A5A back-to-back, dout_ready=1 -> same 4 words in order, one word every 64 cycles, no errors.
REQ-031 Backpressure: dout_ready=0, send 3 words -> first two held in order, overflow=1 after the third completes; then dout_ready=1 -> words 1 and 2 delivered, and overflow stays 1 until clr_err.
REQ-032 Framing: sync at cycle 0, extra sync at cycle 20, followed by word 64'hDEAD_BEEF_0000_0001 starting at cycle 20 -> frame_err=1, exactly one word 64'hDEAD_BEEF_0000_0001 delivered at cycle 84.
REQ-033 Reset mid-word: reset asserted at bit 30, then a full word 64'h5 -> only 64'h5 delivered, and all flags are 0.
REQ-034 Full plus simultaneous pop: FIFO full, pop on the same edge as a push -> push accepted, overflow=0, FIFO still holds 2 entries.
